// File: rtl/rx_lvds_pkg.sv
// Shared sizing for the LVDS receiver: frame length, data-word width and bit-counter width.
package rx_lvds_pkg;

    localparam int unsigned ChNum    = 2;
    localparam int unsigned BuffSize = 8;
    localparam int unsigned NBits    = ChNum * 8;
    localparam int unsigned DataW    = ChNum * BuffSize;
    localparam int unsigned CntW     = $clog2(NBits + 1);

endpackage

// File: rtl/rx_lvds_if.sv
// Hold-register handshake and status between the LVDS receiver and the channel demux.
interface rx_lvds_if;
    import rx_lvds_pkg::*;

    logic [DataW-1:0] data_out;
    logic             rx_valid;
    logic             rx_ready;
    logic             rx_busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        output data_out, rx_valid, rx_busy, frame_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  data_out, rx_valid, rx_busy, frame_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/rx_sync.sv
// Optional delay chain on the serial input; flops preset to 1 so reset looks like an idle line.
module rx_sync #(
    parameter int unsigned Stages = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (Stages == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign q = d;
    end else begin : g_chain
        logic [Stages-1:0] sync_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_q <= '1;
            end else begin
                sync_q <= Stages'({sync_q, d});
            end
        end
        assign q = sync_q[Stages-1];
    end

endmodule

// File: rtl/rx_lvds.sv
// LVDS serial receiver: start 0, NBits data LSB first, stop 1; word presented on a valid/ready
// hold register with frame-error and overrun pulses.
module rx_lvds import rx_lvds_pkg::*; #(
    parameter int unsigned SYNC_STAGES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    rx_lvds_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StData, StStop} state_e;

    logic             rxs;
    state_e           state_q, state_d;
    logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
    logic [NBits-1:0] shift_q, shift_d;
    logic [DataW-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             busy_q;
    logic             ferr_q, ferr_d;
    logic             ovr_q, ovr_d;

    rx_sync #(
        .Stages (SYNC_STAGES)
    ) u_rx_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rxs)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        if (valid_q && bus.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (!rxs) begin
                    state_d   = StData;
                    bit_cnt_d = '0;
                end
            end
            StData: begin
                shift_d   = {rxs, shift_q[NBits-1:1]};
                bit_cnt_d = bit_cnt_q + CntW'(1);
                if (bit_cnt_q == CntW'(NBits - 1)) begin
                    state_d = StStop;
                end
            end
            StStop: begin
                // Always back to IDLE so a start bit on the very next edge is caught.
                state_d = StIdle;
                if (rxs) begin
                    if (!valid_q || bus.rx_ready) begin
                        data_d  = DataW'(shift_q);
                        valid_d = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else begin
                    ferr_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            busy_q    <= (state_d != StIdle);
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.rx_busy   = busy_q;
    assign bus.frame_err = ferr_q;
    assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_rx_lvds.sv
// Directed bench for rx_lvds: drives frames bit-per-clock like TX_LVDS and checks the hold register.
module tb_rx_lvds;
    import rx_lvds_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rx    = 1'b1;

    always #5 clk = ~clk;

    rx_lvds_if bus ();

    rx_lvds #(
        .SYNC_STAGES (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .bus   (bus)
    );

    int unsigned n_pass, n_checks;
    int unsigned cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: capture each word as rx_valid rises, count pulse cycles.
    logic [DataW-1:0] words[$];
    int unsigned      word_cyc[$];
    int unsigned      ferr_cnt, ovr_cnt, both_cnt, valid_hi_cnt;
    logic             prev_valid = 1'b0;

    always @(negedge clk) begin
        if (bus.rx_valid && !prev_valid) begin
            words.push_back(bus.data_out);
            word_cyc.push_back(cyc);
        end
        if (bus.rx_valid) valid_hi_cnt++;
        if (bus.frame_err) ferr_cnt++;
        if (bus.overrun) ovr_cnt++;
        if (bus.frame_err && bus.overrun) both_cnt++;
        prev_valid = bus.rx_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clear_mon();
        words.delete();
        word_cyc.delete();
        ferr_cnt     = 0;
        ovr_cnt      = 0;
        both_cnt     = 0;
        valid_hi_cnt = 0;
    endtask

    task automatic send(input logic [15:0] w, input logic stop, output int unsigned sc);
        @(negedge clk);
        rx = 1'b0;
        sc = cyc;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rx = w[i];
        end
        @(negedge clk);
        rx = stop;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx = 1'b1;
        repeat (n - 1) @(negedge clk);
    endtask

    int unsigned sc0, sc1;

    initial begin
        bus.rx_ready = 1'b0;
        n_pass   = 0;
        n_checks = 0;
        clear_mon();

        // Power-on reset values
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(bus.data_out), 32'h0);
        check_eq("rst_valid", 32'(bus.rx_valid), 32'h0);
        check_eq("rst_busy", 32'(bus.rx_busy), 32'h0);
        check_eq("rst_ferr", 32'(bus.frame_err), 32'h0);
        check_eq("rst_ovr", 32'(bus.overrun), 32'h0);
        rst_n = 1'b1;

        // Idle line for 50 clocks produces nothing
        idle(50);
        check_eq("idle_words", words.size(), 0);
        check_eq("idle_busy", 32'(bus.rx_busy), 32'h0);

        // Single frame, latency and one-cycle valid
        bus.rx_ready = 1'b1;
        clear_mon();
        send(16'hA55A, 1'b1, sc0);
        idle(4);
        check_eq("single_cnt", words.size(), 1);
        if (words.size() == 1) begin
            check_eq("single_data", 32'(words[0]), 32'hA55A);
            check_eq("single_lat", word_cyc[0] - sc0, 18);
        end
        check_eq("single_vhi", valid_hi_cnt, 1);
        check_eq("single_ferr", ferr_cnt, 0);

        // Back-to-back frames with no idle gap
        clear_mon();
        send(16'h0001, 1'b1, sc0);
        send(16'hFFFF, 1'b1, sc1);
        idle(4);
        check_eq("b2b_cnt", words.size(), 2);
        if (words.size() == 2) begin
            check_eq("b2b_w0", 32'(words[0]), 32'h0001);
            check_eq("b2b_w1", 32'(words[1]), 32'hFFFF);
            check_eq("b2b_gap", word_cyc[1] - word_cyc[0], 18);
        end
        check_eq("b2b_ferr", ferr_cnt, 0);

        // Bad stop bit, then a good frame
        clear_mon();
        send(16'h1234, 1'b0, sc0);
        idle(4);
        check_eq("bad_ferr", ferr_cnt, 1);
        check_eq("bad_words", words.size(), 0);
        send(16'h00FF, 1'b1, sc0);
        idle(4);
        check_eq("after_bad_cnt", words.size(), 1);
        if (words.size() == 1) check_eq("after_bad_data", 32'(words[0]), 32'h00FF);

        // Overrun: hold register full, second word dropped
        clear_mon();
        bus.rx_ready = 1'b0;
        send(16'h1111, 1'b1, sc0);
        send(16'h2222, 1'b1, sc1);
        idle(4);
        check_eq("ovr_cnt", ovr_cnt, 1);
        check_eq("ovr_both", both_cnt, 0);
        check_eq("ovr_data", 32'(bus.data_out), 32'h1111);
        check_eq("ovr_valid", 32'(bus.rx_valid), 32'h1);
        bus.rx_ready = 1'b1;
        @(negedge clk);
        check_eq("ovr_consumed", 32'(bus.rx_valid), 32'h0);
        check_eq("ovr_kept", 32'(bus.data_out), 32'h1111);

        // Mid-frame asynchronous reset after 5 data bits
        @(negedge clk);
        rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = i[0];
        end
        @(negedge clk);
        check_eq("mid_busy_pre", 32'(bus.rx_busy), 32'h1);
        #2;
        rst_n = 1'b0;
        rx    = 1'b1;
        #1;
        check_eq("mid_busy", 32'(bus.rx_busy), 32'h0);
        check_eq("mid_data", 32'(bus.data_out), 32'h0);
        check_eq("mid_valid", 32'(bus.rx_valid), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        idle(50);
        check_eq("post_rst_words", words.size(), 0);
        send(16'hBEEF, 1'b1, sc0);
        idle(4);
        check_eq("beef_cnt", words.size(), 1);
        if (words.size() == 1) begin
            check_eq("beef_data", 32'(words[0]), 32'hBEEF);
            check_eq("beef_lat", word_cyc[0] - sc0, 18);
        end
        check_eq("beef_ferr", ferr_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
